// File: rtl/reassembly_queue_dequeue.sv
// reassembly_queue_dequeue: queues completed reassembly queues and streams their fragments downstream in order.
module reassembly_queue_dequeue #(
  parameter int DW = 32,
  parameter int PEND_AW = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [4:0]    iv_queue_id,
  input  logic [3:0]    iv_queue_usedw,
  input  logic          i_queue_done_wr,
  input  logic [31:0]   iv_queue_empty,
  output logic          o_frag_rd,
  output logic [4:0]    ov_frag_rd_qid,
  input  logic [DW-1:0] iv_frag_rdata,
  input  logic          i_frag_rdata_valid,
  output logic [DW-1:0] ov_desc,
  output logic [3:0]    ov_desc_frag_id,
  output logic          o_desc_last,
  output logic          o_desc_wr,
  input  logic          i_desc_ready,
  output logic [4:0]    ov_queue_id_free,
  output logic          o_queue_id_free_wr,
  output logic          o_pend_full,
  output logic          o_overflow_pulse,
  output logic          o_underflow_pulse
);
  localparam int DEPTH = 1 << PEND_AW;
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, WAIT = 3'd2, OUT = 3'd3, FREE = 3'd4;
  logic [2:0] state;
  logic [8:0] mem [DEPTH];
  logic [PEND_AW-1:0] wr_ptr, rd_ptr;
  logic [PEND_AW:0] count, count_nxt;
  logic [4:0] qid;
  logic [3:0] last_idx, frag_idx;
  logic pop, push, full;
  assign full = count == (PEND_AW+1)'(DEPTH);
  assign pop = state == IDLE && count != '0;
  // a full FIFO still accepts a completion in the cycle the FSM pops
  assign push = i_queue_done_wr && (!full || pop);
  assign count_nxt = count + (PEND_AW+1)'(push) - (PEND_AW+1)'(pop);
  assign o_frag_rd = state == READ && !iv_queue_empty[qid];
  assign ov_frag_rd_qid = o_frag_rd ? qid : '0;
  assign o_underflow_pulse = state == READ && iv_queue_empty[qid];
  assign o_queue_id_free_wr = state == FREE;
  assign ov_queue_id_free = o_queue_id_free_wr ? qid : '0;
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {iv_queue_id, iv_queue_usedw};
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      qid <= '0;
      last_idx <= '0;
      frag_idx <= '0;
      ov_desc <= '0;
      ov_desc_frag_id <= '0;
      o_desc_last <= 1'b0;
      o_desc_wr <= 1'b0;
      o_pend_full <= 1'b0;
      o_overflow_pulse <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      o_pend_full <= count_nxt == (PEND_AW+1)'(DEPTH);
      o_overflow_pulse <= i_queue_done_wr && !push;
      case (state)
        IDLE: if (pop) begin
          {qid, last_idx} <= mem[rd_ptr];
          frag_idx <= '0;
          state <= READ;
        end
        READ: state <= iv_queue_empty[qid] ? FREE : WAIT;
        WAIT: if (i_frag_rdata_valid) begin
          ov_desc <= iv_frag_rdata;
          ov_desc_frag_id <= frag_idx;
          o_desc_last <= frag_idx == last_idx;
          o_desc_wr <= 1'b1;
          state <= OUT;
        end
        OUT: if (i_desc_ready) begin
          o_desc_wr <= 1'b0;
          frag_idx <= frag_idx == last_idx ? frag_idx : frag_idx + 1'b1;
          state <= frag_idx == last_idx ? FREE : READ;
        end
        FREE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reassembly_queue_dequeue.sv
// tb_reassembly_queue_dequeue: scoreboard bench; a packet queue model predicts reads, descriptors and frees.
module tb_reassembly_queue_dequeue;
  typedef struct {logic [4:0] qid; logic [3:0] usedw;} pkt_t;
  logic i_clk, i_rst, i_queue_done_wr, i_frag_rdata_valid, i_desc_ready;
  logic [4:0] iv_queue_id, ov_frag_rd_qid, ov_queue_id_free;
  logic [3:0] iv_queue_usedw, ov_desc_frag_id;
  logic [31:0] iv_queue_empty, iv_frag_rdata, ov_desc;
  logic o_frag_rd, o_desc_last, o_desc_wr, o_queue_id_free_wr, o_pend_full, o_overflow_pulse, o_underflow_pulse;
  int vectors = 0, miscompares = 0;
  int n_rd = 0, n_desc = 0, n_free = 0, n_under = 0, cyc = 0, acc_cyc = 0, free_cyc = 0;
  int exp_frag = 0, resp_cnt = 0, max_lat = 1;
  pkt_t exp_q[$];
  pkt_t f;
  logic [31:0] data_q[$];
  logic [31:0] p_desc;
  logic [3:0] p_id;
  logic p_last, stalled = 0;

  reassembly_queue_dequeue #(.DW(32), .PEND_AW(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .iv_queue_id(iv_queue_id), .iv_queue_usedw(iv_queue_usedw),
    .i_queue_done_wr(i_queue_done_wr), .iv_queue_empty(iv_queue_empty), .o_frag_rd(o_frag_rd),
    .ov_frag_rd_qid(ov_frag_rd_qid), .iv_frag_rdata(iv_frag_rdata), .i_frag_rdata_valid(i_frag_rdata_valid),
    .ov_desc(ov_desc), .ov_desc_frag_id(ov_desc_frag_id), .o_desc_last(o_desc_last), .o_desc_wr(o_desc_wr),
    .i_desc_ready(i_desc_ready), .ov_queue_id_free(ov_queue_id_free), .o_queue_id_free_wr(o_queue_id_free_wr),
    .o_pend_full(o_pend_full), .o_overflow_pulse(o_overflow_pulse), .o_underflow_pulse(o_underflow_pulse)
  );

  initial begin
    i_clk = 0;
    forever #5 i_clk = ~i_clk;
  end
  always @(posedge i_clk) cyc <= cyc + 1;

  // queue-memory model: answers each read after 1..max_lat cycles with a fresh random descriptor
  initial forever begin
    @(negedge i_clk);
    i_frag_rdata_valid = 0;
    if (i_rst) resp_cnt = 0;
    else begin
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          i_frag_rdata_valid = 1;
          iv_frag_rdata = $urandom;
          data_q.push_back(iv_frag_rdata);
        end
      end
      if (o_frag_rd) resp_cnt = $urandom_range(1, max_lat);
    end
  end

  always @(negedge i_clk) begin
    if (i_rst) begin
      exp_q.delete();
      data_q.delete();
      exp_frag = 0;
      stalled = 0;
    end else begin
      f = exp_q.size() > 0 ? exp_q[0] : '{qid: 'x, usedw: 'x};
      if (o_frag_rd) begin
        n_rd++; vectors++;
        if (ov_frag_rd_qid !== f.qid || iv_queue_empty[f.qid] !== 1'b0) begin
          miscompares++; $display("FAIL rd_qid: got %0d want %0d", ov_frag_rd_qid, f.qid);
        end
      end
      if (o_underflow_pulse) begin
        n_under++; vectors++;
        if (iv_queue_empty[f.qid] !== 1'b1 || exp_frag != 0) begin
          miscompares++; $display("FAIL underflow: unexpected for qid %0d", f.qid);
        end
      end
      if (stalled) begin
        vectors++;
        if (o_desc_wr !== 1'b1 || ov_desc !== p_desc || ov_desc_frag_id !== p_id || o_desc_last !== p_last) begin
          miscompares++; $display("FAIL desc_hold: got %h/%0d/%b want %h/%0d/%b", ov_desc, ov_desc_frag_id, o_desc_last, p_desc, p_id, p_last);
        end
      end
      if (o_desc_wr && i_desc_ready) begin
        n_desc++; vectors++; acc_cyc = cyc;
        if (ov_desc !== (data_q.size() > 0 ? data_q[0] : 32'hx) || ov_desc_frag_id !== 4'(exp_frag)
            || o_desc_last !== (exp_frag == int'(f.usedw))) begin
          miscompares++; $display("FAIL desc: got %h id %0d last %b want %h id %0d last %b", ov_desc, ov_desc_frag_id, o_desc_last,
                                  data_q.size() > 0 ? data_q[0] : 32'hx, exp_frag, exp_frag == int'(f.usedw));
        end
        if (data_q.size() > 0) void'(data_q.pop_front());
        exp_frag++;
      end
      stalled = o_desc_wr && !i_desc_ready;
      p_desc = ov_desc; p_id = ov_desc_frag_id; p_last = o_desc_last;
      if (o_queue_id_free_wr) begin
        n_free++; vectors++; free_cyc = cyc;
        if (ov_queue_id_free !== f.qid || !(exp_frag == int'(f.usedw) + 1 || iv_queue_empty[f.qid] === 1'b1)) begin
          miscompares++; $display("FAIL free: got qid %0d after %0d frags, want qid %0d", ov_queue_id_free, exp_frag, f.qid);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        exp_frag = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic push_done(input logic [4:0] q, input logic [3:0] u);
    @(posedge i_clk); #1;
    i_queue_done_wr = 1; iv_queue_id = q; iv_queue_usedw = u;
    exp_q.push_back('{qid: q, usedw: u});
    @(posedge i_clk); #1;
    i_queue_done_wr = 0;
  endtask

  task automatic wait_desc();
    int t;
    for (t = 0; t < 200 && o_desc_wr !== 1'b1; t++) begin
      @(posedge i_clk); #1;
    end
    if (t == 200) begin
      vectors++; miscompares++; $display("FAIL wait_desc: timeout, got desc_wr %b want 1", o_desc_wr);
    end
  endtask

  task automatic accept_one();
    wait_desc();
    i_desc_ready = 1;
    @(posedge i_clk); #1;
    i_desc_ready = 0;
  endtask

  task automatic drain();
    int t;
    for (t = 0; t < 5000 && exp_q.size() != 0; t++) begin
      @(posedge i_clk); #1;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++; $display("FAIL drain: %0d packets outstanding, want 0", exp_q.size());
    end
    repeat (10) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1;
    repeat (3) @(posedge i_clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      vectors++;
      if ({o_frag_rd, ov_frag_rd_qid, o_desc_wr, o_desc_last, ov_desc_frag_id, o_queue_id_free_wr, ov_queue_id_free,
           o_pend_full, o_overflow_pulse, o_underflow_pulse} !== '0) begin
        miscompares++; $display("FAIL reset_ctrl: got nonzero control outputs, want 0");
      end
      vectors++;
      if (ov_desc !== '0) begin
        miscompares++; $display("FAIL reset_desc: got %h want 0", ov_desc);
      end
      i_rst = 0;
      repeat (3) @(posedge i_clk);
      #1;
    end
  endtask

  task automatic test_single();
    int r0 = n_rd, d0 = n_desc, f0 = n_free;
    i_desc_ready = 1; max_lat = 1;
    push_done(5'd3, 4'd0);
    drain();
    vectors++;
    if (n_rd - r0 != 1 || n_desc - d0 != 1 || n_free - f0 != 1) begin
      miscompares++; $display("FAIL single_counts: got rd %0d desc %0d free %0d want 1 1 1", n_rd - r0, n_desc - d0, n_free - f0);
    end
    vectors++;
    if (free_cyc - acc_cyc != 1) begin
      miscompares++; $display("FAIL single_free_delay: got %0d want 1", free_cyc - acc_cyc);
    end
  endtask

  task automatic test_backpressure();
    int r0 = n_rd, d0 = n_desc, f0 = n_free;
    i_desc_ready = 0; max_lat = 2;
    push_done(5'd7, 4'd3);
    for (int k = 0; k < 4; k++) begin
      wait_desc();
      if (k == 1) repeat (5) @(posedge i_clk);
      #1;
      accept_one();
    end
    drain();
    vectors++;
    if (n_rd - r0 != 4 || n_desc - d0 != 4 || n_free - f0 != 1) begin
      miscompares++; $display("FAIL bp_counts: got rd %0d desc %0d free %0d want 4 4 1", n_rd - r0, n_desc - d0, n_free - f0);
    end
  endtask

  task automatic test_fifo_full();
    int r0;
    i_desc_ready = 0; max_lat = 1;
    push_done(5'd20, 4'd0);
    wait_desc();
    for (int k = 0; k < 9; k++) begin
      @(posedge i_clk); #1;
      if (k >= 7) begin
        vectors++;
        if (o_pend_full !== (k == 8)) begin
          miscompares++; $display("FAIL pend_full_%0d: got %b want %b", k, o_pend_full, k == 8);
        end
      end
      i_queue_done_wr = 1; iv_queue_id = 5'(k); iv_queue_usedw = 0;
      if (k < 8) exp_q.push_back('{qid: 5'(k), usedw: 4'd0});
    end
    @(posedge i_clk); #1;
    i_queue_done_wr = 0;
    vectors++;
    if (o_overflow_pulse !== 1'b1) begin
      miscompares++; $display("FAIL overflow: got %b want 1", o_overflow_pulse);
    end
    @(posedge i_clk); #1;
    vectors++;
    if (o_overflow_pulse !== 1'b0) begin
      miscompares++; $display("FAIL overflow_width: got %b want 0", o_overflow_pulse);
    end
    i_desc_ready = 1;
    drain();
    r0 = n_rd;
    repeat (20) @(posedge i_clk);
    #1;
    vectors++;
    if (n_rd != r0 || o_pend_full !== 1'b0) begin
      miscompares++; $display("FAIL dropped_entry: got %0d extra reads, full %b, want 0 0", n_rd - r0, o_pend_full);
    end
  endtask

  task automatic test_underflow();
    int r0 = n_rd, d0 = n_desc, f0 = n_free, u0 = n_under;
    i_desc_ready = 1;
    iv_queue_empty = 32'h1 << 12;
    push_done(5'd12, 4'd2);
    drain();
    vectors++;
    if (n_rd != r0 || n_desc != d0 || n_free - f0 != 1 || n_under - u0 != 1) begin
      miscompares++; $display("FAIL underflow_counts: got rd %0d desc %0d free %0d under %0d want 0 0 1 1",
                              n_rd - r0, n_desc - d0, n_free - f0, n_under - u0);
    end
    iv_queue_empty = 0;
  endtask

  task automatic test_back_to_back();
    int t;
    i_desc_ready = 0; max_lat = 1;
    push_done(5'd5, 4'd0);
    wait_desc();
    push_done(5'd6, 4'd1);
    i_desc_ready = 1;
    for (t = 0; t < 100 && o_queue_id_free_wr !== 1'b1; t++) begin
      @(posedge i_clk); #1;
    end
    @(posedge i_clk); #1;
    i_queue_done_wr = 1; iv_queue_id = 5'd10; iv_queue_usedw = 0;
    exp_q.push_back('{qid: 5'd10, usedw: 4'd0});
    @(posedge i_clk); #1;
    i_queue_done_wr = 0;
    vectors++;
    if (dut.count !== 4'd1 || t == 100) begin
      miscompares++; $display("FAIL simul_count: got %0d want 1", dut.count);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int f0, d0;
    i_desc_ready = 0; max_lat = 1;
    push_done(5'd9, 4'd5);
    accept_one();
    accept_one();
    wait_desc();
    f0 = n_free;
    #2 i_rst = 1;
    #1;
    vectors++;
    if ({o_frag_rd, o_desc_wr, o_desc_last, ov_desc_frag_id, o_queue_id_free_wr, ov_desc, o_pend_full, o_underflow_pulse} !== '0) begin
      miscompares++; $display("FAIL async_reset: got desc_wr %b id %0d desc %h want 0", o_desc_wr, ov_desc_frag_id, ov_desc);
    end
    repeat (2) @(posedge i_clk);
    #1 i_rst = 0;
    repeat (5) @(posedge i_clk);
    #1;
    vectors++;
    if (n_free != f0) begin
      miscompares++; $display("FAIL reset_free: got %0d frees want 0", n_free - f0);
    end
    d0 = n_desc;
    i_desc_ready = 1;
    push_done(5'd9, 4'd1);
    drain();
    vectors++;
    if (n_desc - d0 != 2 || n_free - f0 != 1) begin
      miscompares++; $display("FAIL post_reset: got desc %0d free %0d want 2 1", n_desc - d0, n_free - f0);
    end
  endtask

  task automatic test_random();
    int pk = 0;
    max_lat = 3;
    iv_queue_empty = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
    for (int c = 0; c < 1500; c++) begin
      @(posedge i_clk); #1;
      i_desc_ready = $urandom_range(0, 3) != 0;
      i_queue_done_wr = 0;
      if (exp_q.size() < 7 && pk < 40 && $urandom_range(0, 3) == 0) begin
        i_queue_done_wr = 1; iv_queue_id = 5'($urandom); iv_queue_usedw = 4'($urandom);
        exp_q.push_back('{qid: iv_queue_id, usedw: iv_queue_usedw});
        pk++;
      end
    end
    @(posedge i_clk); #1;
    i_queue_done_wr = 0; i_desc_ready = 1;
    drain();
    iv_queue_empty = 0;
  endtask

  initial begin
    i_rst = 1; i_queue_done_wr = 0; iv_queue_id = 0; iv_queue_usedw = 0;
    iv_queue_empty = 0; i_desc_ready = 0; i_frag_rdata_valid = 0; iv_frag_rdata = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_fifo_full();
    test_underflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
